// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 register-slave bus master: slave address map,
// control/status bit positions and the master FSM state encoding.
package sha256_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    localparam int BLOCK_WORDS  = 16;
    localparam int DIGEST_WORDS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POLL_RDY  = 3'd1,
        WR_BLK    = 3'd2,
        WR_CTRL   = 3'd3,
        GUARD     = 3'd4,
        POLL_DONE = 3'd5,
        RD_DIG    = 3'd6,
        DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/sha256_master.sv
// Feeds 512-bit blocks to a SHA-256 register slave and reads back the digest.
// Bus outputs are registered; one counter serves word index, guard delay and poll timeout.
module sha256_master
    import sha256_pkg::*;
#(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic         blk_ready,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         error
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2((CNT_MAX > BLOCK_WORDS) ? CNT_MAX : BLOCK_WORDS) + 1;

    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLOCK   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_DIGEST  = CNT_W'(DIGEST_WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [511:0]     blk_buf;
    logic             first_q;

    assign blk_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            blk_buf      <= '0;
            first_q      <= 1'b0;
            cs           <= 1'b0;
            we           <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Bus parks at all-zero unless the current state drives it for the next cycle.
            cs           <= 1'b0;
            we           <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            digest_valid <= 1'b0;
            error        <= 1'b0;

            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        blk_buf <= blk_data;
                        first_q <= blk_first;
                        cnt     <= '0;
                        state   <= POLL_RDY;
                        cs      <= 1'b1;
                        address <= ADDR_STATUS;
                    end
                end

                POLL_RDY: begin
                    if (read_data[STATUS_READY_BIT]) begin
                        cnt        <= '0;
                        state      <= WR_BLK;
                        cs         <= 1'b1;
                        we         <= 1'b1;
                        address    <= ADDR_BLOCK;
                        write_data <= blk_buf[511:480];
                        blk_buf    <= {blk_buf[479:0], 32'h0};
                    end else if (cnt == CNT_TIMEOUT) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        cs      <= 1'b1;
                        address <= ADDR_STATUS;
                    end
                end

                // blk_buf is shifted so the next word to send is always in the top 32 bits.
                WR_BLK: begin
                    cs <= 1'b1;
                    we <= 1'b1;
                    if (cnt == CNT_BLOCK) begin
                        state      <= WR_CTRL;
                        address    <= ADDR_CTRL;
                        write_data <= first_q ? (32'd1 << CTRL_INIT_BIT)
                                              : (32'd1 << CTRL_NEXT_BIT);
                    end else begin
                        cnt        <= cnt + CNT_W'(1);
                        address    <= address + 8'd1;
                        write_data <= blk_buf[511:480];
                        blk_buf    <= {blk_buf[479:0], 32'h0};
                    end
                end

                WR_CTRL: begin
                    cnt <= '0;
                    if (GUARD_CYCLES == 0) begin
                        state   <= POLL_DONE;
                        cs      <= 1'b1;
                        address <= ADDR_STATUS;
                    end else begin
                        state <= GUARD;
                    end
                end

                GUARD: begin
                    if (cnt == CNT_GUARD) begin
                        cnt     <= '0;
                        state   <= POLL_DONE;
                        cs      <= 1'b1;
                        address <= ADDR_STATUS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                POLL_DONE: begin
                    if (read_data[STATUS_READY_BIT] && read_data[STATUS_VALID_BIT]) begin
                        cnt     <= '0;
                        state   <= RD_DIG;
                        cs      <= 1'b1;
                        address <= ADDR_DIGEST;
                    end else if (cnt == CNT_TIMEOUT) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        cs      <= 1'b1;
                        address <= ADDR_STATUS;
                    end
                end

                RD_DIG: begin
                    for (int i = 0; i < DIGEST_WORDS; i++) begin
                        if (cnt[2:0] == 3'(i)) digest[255-32*i -: 32] <= read_data;
                    end
                    if (cnt == CNT_DIGEST) begin
                        state        <= DONE;
                        digest_valid <= 1'b1;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        cs      <= 1'b1;
                        address <= address + 8'd1;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_master.sv
// Bench for sha256_master: behavioural SHA-256 slave, message-level digest model and
// a queue-based scoreboard/bus monitor running on the falling clock edge.
module tb_sha256_master;

    localparam int G  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_ready;
    logic         cs, we;
    logic [7:0]   address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic [255:0] digest;
    logic         digest_valid;
    logic         error;

    always #5 clk = ~clk;

    sha256_master #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_first(blk_first), .blk_ready(blk_ready), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .digest(digest),
        .digest_valid(digest_valid), .error(error)
    );

    logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
        logic [31:0] w [0:63];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, bb, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Register slave: block/ctrl writes, status and digest reads, random busy latency.
    logic [511:0] slv_blk = '0;
    logic [255:0] slv_h = '0;
    int           busy = 0;
    int           nrdy = 0;
    logic         dvalid = 1'b0;
    bit           stub = 1'b0;

    always @(posedge clk) begin
        if (cs && we && address[7:4] == 4'h1) begin
            slv_blk[511 - 32*int'(address[3:0]) -: 32] <= write_data;
        end else if (cs && we && address == 8'h08) begin
            if (write_data[0]) slv_h <= sha_compress(IV, slv_blk);
            else if (write_data[1]) slv_h <= sha_compress(slv_h, slv_blk);
            busy   <= int'($urandom_range(1, 8));
            dvalid <= 1'b0;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) dvalid <= 1'b1;
        end
        if (cs && !we && address == 8'h27) nrdy <= int'($urandom_range(0, 4));
        else if (nrdy != 0) nrdy <= nrdy - 1;
    end

    always_comb begin
        read_data = '0;
        if (cs && !we) begin
            if (address == 8'h09)
                read_data = stub ? 32'h0 : {30'd0, dvalid, (busy == 0 && nrdy == 0)};
            else if (address[7:3] == 5'b00100)
                read_data = slv_h[255 - 32*int'(address[2:0]) -: 32];
        end
    end

    typedef struct {
        bit           err;
        bit           first;
        logic [255:0] dig;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired, got no event, required DUT response", name);
    endtask

    // Monitor state for the transaction currently on the bus.
    int   wr_idx, rd_idx, ctrl_n, gap, st_n;
    bit   ord_bad, other_bad, zero_bad, rdy_leak, gap_on, in_flight;
    logic [31:0]  ctrl_v;
    logic [255:0] last_dig = '0;

    task automatic mon_clear();
        wr_idx = 0; rd_idx = 0; ctrl_n = 0; gap = 0; st_n = 0;
        ord_bad = 0; other_bad = 0; zero_bad = 0; rdy_leak = 0; gap_on = 0;
        ctrl_v = '0;
    endtask

    initial begin : monitor
        exp_t e;
        mon_clear();
        in_flight = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_clear();
                in_flight = 0;
                last_dig  = '0;
            end else begin
                if (blk_valid && blk_ready) begin
                    mon_clear();
                    in_flight = 1;
                end else if (in_flight && blk_ready) begin
                    rdy_leak = 1;
                end
                if (!cs && (we || address != 8'h0 || write_data != 32'h0)) zero_bad = 1;
                if (cs) begin
                    gap_on = 0;
                    if (we && address[7:4] == 4'h1) begin
                        if (int'(address[3:0]) != wr_idx) ord_bad = 1;
                        wr_idx++;
                    end else if (we && address == 8'h08) begin
                        ctrl_n++;
                        ctrl_v = write_data;
                        gap_on = 1;
                        gap    = 0;
                    end else if (!we && address == 8'h09) begin
                        st_n++;
                    end else if (!we && address[7:3] == 5'b00100) begin
                        if (int'(address[2:0]) != rd_idx) ord_bad = 1;
                        rd_idx++;
                    end else begin
                        other_bad = 1;
                    end
                end else if (gap_on) begin
                    gap++;
                end

                if (digest_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_digest_valid");
                    end else begin
                        e = exp_q.pop_front();
                        chk("outcome_is_digest", 256'(e.err), 256'(0));
                        chk("digest", digest, e.dig);
                        chk("bus_block_writes", 256'(wr_idx), 256'(16));
                        chk("bus_ctrl", {ctrl_n, ctrl_v}, {32'd1, (e.first ? 32'd1 : 32'd2)});
                        chk("bus_guard_gap", 256'(gap), 256'(G));
                        chk("bus_digest_reads", 256'(rd_idx), 256'(8));
                        chk("bus_protocol", {ord_bad, other_bad, zero_bad, rdy_leak}, 256'(0));
                    end
                    last_dig  = digest;
                    in_flight = 0;
                end
                if (error) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_error");
                    end else begin
                        e = exp_q.pop_front();
                        chk("outcome_is_error", 256'(e.err), 256'(1));
                        chk("timeout_status_reads", 256'(st_n), 256'(TO));
                        chk("digest_kept_on_error", digest, last_dig);
                        chk("no_block_writes_on_error", 256'(wr_idx), 256'(0));
                    end
                    in_flight = 0;
                end
            end
        end
    end

    logic [255:0] mh = '0;

    task automatic model_step(input logic [511:0] b, input bit first, output logic [255:0] res);
        if (first) mh = IV;
        mh  = sha_compress(mh, b);
        res = mh;
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
        return r;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!blk_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!blk_ready) fail_now(name);
    endtask

    task automatic wait_q(input int sz, input string name);
        int n = 0;
        while (exp_q.size() > sz && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > sz) begin
            fail_now(name);
            exp_q.delete();
        end
    endtask

    task automatic offer(input logic [511:0] b, input bit first);
        blk_data  = b;
        blk_first = first;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_data  = rnd_blk();
        blk_first = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [511:0] b, input bit first, input bit err, input logic [255:0] dig);
        wait_ready("wait_blk_ready");
        exp_q.push_back('{err: err, first: first, dig: dig});
        offer(b, first);
        wait_q(0, "wait_completion");
    endtask

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
        32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    initial begin : stimulus
        logic [255:0] ed, ea, eb;
        logic [511:0] b, ba, bb;
        bit           f;
        int           n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", 256'(cs), 256'(0));
        chk("rst_we", 256'(we), 256'(0));
        chk("rst_address", 256'(address), 256'(0));
        chk("rst_write_data", 256'(write_data), 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_pulses", {digest_valid, error}, 256'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("blk_ready_after_reset", 256'(blk_ready), 256'(1));

        model_step(ABC_BLK, 1'b1, ed);
        send(ABC_BLK, 1'b1, 1'b0, ABC_DIG);

        model_step(TWO_BLK1, 1'b1, ed);
        send(TWO_BLK1, 1'b1, 1'b0, ed);
        model_step(TWO_BLK2, 1'b0, ed);
        send(TWO_BLK2, 1'b0, 1'b0, TWO_DIG);

        for (int k = 0; k < 6; k++) begin
            b = rnd_blk();
            f = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            model_step(b, f, ed);
            send(b, f, 1'b0, ed);
        end

        // blk_valid held high across a whole transaction with the next block waiting.
        ba = rnd_blk();
        bb = rnd_blk();
        model_step(ba, 1'b1, ea);
        model_step(bb, 1'b0, eb);
        wait_ready("wait_blk_ready_held");
        exp_q.push_back('{err: 1'b0, first: 1'b1, dig: ea});
        exp_q.push_back('{err: 1'b0, first: 1'b0, dig: eb});
        blk_data  = ba;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_data  = bb;
        blk_first = 1'b0;
        wait_q(1, "wait_held_first");
        chk("held_ready_after_done", 256'(blk_ready), 256'(1));
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_data  = rnd_blk();
        chk("held_second_captured", 256'(blk_ready), 256'(0));
        wait_q(0, "wait_held_second");

        stub = 1'b1;
        send(rnd_blk(), 1'b1, 1'b1, '0);
        stub = 1'b0;
        chk("idle_after_timeout", 256'(blk_ready), 256'(1));

        // Reset while block word 7 is on the bus.
        wait_ready("wait_blk_ready_rst");
        exp_q.push_back('{err: 1'b0, first: 1'b1, dig: ABC_DIG});
        offer(ABC_BLK, 1'b1);
        n = 0;
        while (!(cs && we && address == 8'h17) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(cs && we && address == 8'h17)) fail_now("wait_word7");
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_bus", {cs, we, address, write_data}, 256'(0));
        chk("midrst_digest", digest, 256'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_quiet", {cs, blk_ready}, 256'(1));

        model_step(ABC_BLK, 1'b1, ed);
        send(ABC_BLK, 1'b1, 1'b0, ABC_DIG);
        b = rnd_blk();
        model_step(b, 1'b0, ed);
        send(b, 1'b0, 1'b0, ed);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha256_master.md
SHA256_MASTER -- requirements
Module: sha256_master

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: idle cycles after the control write, before completion polling starts.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum status reads per polling phase before error.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 blk_valid  in  1  block offered.
REQ-006 blk_data  in  512  message block; word0 = bits 511:480.
REQ-007 blk_first  in  1  1 = first block of message (init), 0 = continuation (next).
REQ-008 blk_ready  out  1  master can accept a block.
REQ-009 cs  out  1  bus select to SHA-256 register slave.
REQ-010 we  out  1  bus write enable.
REQ-011 address  out  8  bus word address.
REQ-012 write_data  out  32  bus write data.
REQ-013 read_data  in  32  bus read data; combinational from slave, valid in same cycle as cs=1, we=0.
REQ-014 digest  out  256  last digest; digest word0 = bits 255:224.
REQ-015 digest_valid  out  1  one-cycle pulse when digest updated.
REQ-016 error  out  1  one-cycle pulse on poll timeout.

Function
REQ-017 Address map: CTRL 0x08 (bit0 init, bit1 next); STATUS 0x09 (bit0 ready, bit1 digest_valid); BLOCK 0x10-0x1F; DIGEST 0x20-0x27.
REQ-018 cs, we, address, write_data SHALL be registered; cs=0 means we=0, address=0, write_data=0.
REQ-019 States: IDLE, POLL_RDY, WR_BLK, WR_CTRL, GUARD, POLL_DONE, RD_DIG, DONE.
REQ-020 blk_ready SHALL be 1 only in IDLE; blk_valid & blk_ready captures blk_data and blk_first, then goes to POLL_RDY.
REQ-021 POLL_RDY: status read (0x09) every cycle; on read_data[0]=1 go to WR_BLK.
REQ-022 WR_BLK: exactly 16 consecutive writes, address 0x10+i, data block word i, i=0..15 in order.
REQ-023 WR_CTRL: one write to 0x08, data 32'h1 if blk_first else 32'h2.
REQ-024 GUARD: cs=0 for exactly GUARD_CYCLES cycles, counter reloaded on entry.
REQ-025 POLL_DONE: status read every cycle; on read_data[1:0]=2'b11 go to RD_DIG.
REQ-026 RD_DIG: 8 consecutive reads, address 0x20+i; read_data captured into digest word i at cycle end.
REQ-027 DONE: digest_valid=1 for one cycle, then IDLE; digest holds until next completion.
REQ-028 Poll counter cleared on entry to POLL_RDY/POLL_DONE; after TIMEOUT_CYCLES reads without success: error pulse, cs=0, return to IDLE, digest unchanged, no digest_valid.
REQ-029 blk_valid while not IDLE SHALL be ignored (no capture); upstream holds data.
REQ-030 blk_data changes after capture SHALL not affect the in-flight transaction.

Reset
REQ-031 On reset_n=0, immediately: state IDLE, cs/we/address/write_data/digest = 0, digest_valid=0, error=0, counters=0; blk_ready=1 after release.
REQ-032 Reset mid-transaction SHALL abort it with no further bus activity; the next block restarts from POLL_RDY.

Structure
REQ-033 Shared package sha256_pkg: address localparams, CTRL/STATUS bit indices, state enum.
REQ-034 Single module, no sub-module; one counter serves word index, guard, and timeout.

Verification
REQ-035 blk_first=1, block word0=32'h61626380, words1-14=0, word15=32'h00000018 ("abc") -> digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, one digest_valid pulse.
REQ-036 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block1 first=1, block2 first=0) -> final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-037 Bus monitor per block: exactly 16 writes 0x10..0x1F in order, 1 CTRL write, GUARD_CYCLES cs-low cycles, 8 reads 0x20..0x27.
REQ-038 blk_valid held high through a transaction -> blk_ready=0, second block captured only after DONE.
REQ-039 Stub slave with status always 0, TIMEOUT_CYCLES=16 -> 16 status reads, error pulse, IDLE, no digest_valid.
REQ-040 reset_n low during WR_BLK word 7 -> cs=0 immediately; reissue block -> correct digest.
